user_stream_adapter_n: RTL

//  Parametrised, buffered stream adapter between the PCIe stream engine and user logic.

---
 rtl/user_stream_adapter_n.sv | 121 ++++++++++++
 1 files changed

// File: rtl/user_stream_adapter_n.sv
// Buffered NUM_STR-channel stream adapter between the PCIe stream engine and user logic.
// Each channel has an H2U and a U2H first-word-fall-through FIFO plus a per-channel loopback path.
module user_stream_adapter_n #(
    parameter int unsigned NUM_STR    = 4,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned FIFO_DEPTH = 16,
    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                        i_user_clk,
    input  logic                        i_rst,
    input  logic [NUM_STR-1:0]          i_loopback,
    input  logic [NUM_STR-1:0]          i_pcie_str_data_valid,
    output logic [NUM_STR-1:0]          o_pcie_str_ack,
    input  logic [NUM_STR*DATA_W-1:0]   i_pcie_str_data,
    output logic [NUM_STR-1:0]          o_pcie_str_data_valid,
    input  logic [NUM_STR-1:0]          i_pcie_str_ack,
    output logic [NUM_STR*DATA_W-1:0]   o_pcie_str_data,
    output logic [NUM_STR-1:0]          o_usr_str_data_valid,
    input  logic [NUM_STR-1:0]          i_usr_str_ack,
    output logic [NUM_STR*DATA_W-1:0]   o_usr_str_data,
    input  logic [NUM_STR-1:0]          i_usr_str_data_valid,
    output logic [NUM_STR-1:0]          o_usr_str_ack,
    input  logic [NUM_STR*DATA_W-1:0]   i_usr_str_data,
    output logic [NUM_STR*LVL_W-1:0]    o_h2u_level,
    output logic [NUM_STR*LVL_W-1:0]    o_u2h_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic               r_init;
    logic [NUM_STR-1:0] r_lb;

    // Init flag gates every ack until the first edge after reset; loopback select is registered
    always_ff @(posedge i_user_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_init <= 1'b0;
            r_lb   <= '0;
        end else begin
            r_init <= 1'b1;
            r_lb   <= i_loopback;
        end
    end

    for (genvar k = 0; k < NUM_STR; k++) begin : g_ch
        logic [DATA_W-1:0] h_mem [FIFO_DEPTH];
        logic [DATA_W-1:0] u_mem [FIFO_DEPTH];
        logic [PTR_W-1:0]  h_wr, h_rd, h_wr_nx, h_rd_nx;
        logic [PTR_W-1:0]  u_wr, u_rd, u_wr_nx, u_rd_nx;
        logic [LVL_W-1:0]  h_lvl, h_lvl_nx, u_lvl, u_lvl_nx;
        logic              h_full, h_empty, h_in_ack, h_push, h_pop;
        logic              u_full, u_empty, u_in_ack, u_push, u_pop;
        logic              u_in_valid, usr_valid;
        logic [DATA_W-1:0] h_head, u_head, u_in_data;

        assign h_full   = (h_lvl == LVL_W'(FIFO_DEPTH));
        assign h_empty  = (h_lvl == '0);
        assign u_full   = (u_lvl == LVL_W'(FIFO_DEPTH));
        assign u_empty  = (u_lvl == '0);
        assign h_head   = h_mem[h_rd];
        assign u_head   = u_mem[u_rd];
        assign h_in_ack = r_init & ~h_full;
        assign u_in_ack = r_init & ~u_full;

        // In loopback the H2U head feeds the U2H input and the user side is fenced off
        assign u_in_valid = r_lb[k] ? ~h_empty : i_usr_str_data_valid[k];
        assign u_in_data  = r_lb[k] ? h_head   : i_usr_str_data[k*DATA_W +: DATA_W];
        assign usr_valid  = ~h_empty & ~r_lb[k];

        assign h_push = i_pcie_str_data_valid[k] & h_in_ack;
        assign h_pop  = r_lb[k] ? (~h_empty & u_in_ack) : (usr_valid & i_usr_str_ack[k]);
        assign u_push = u_in_valid & u_in_ack;
        assign u_pop  = ~u_empty & i_pcie_str_ack[k];

        always_comb begin
            h_wr_nx  = h_wr;
            h_rd_nx  = h_rd;
            u_wr_nx  = u_wr;
            u_rd_nx  = u_rd;
            h_lvl_nx = h_lvl + LVL_W'(h_push) - LVL_W'(h_pop);
            u_lvl_nx = u_lvl + LVL_W'(u_push) - LVL_W'(u_pop);
            if (h_push) h_wr_nx = h_wr + PTR_W'(1);
            if (h_pop)  h_rd_nx = h_rd + PTR_W'(1);
            if (u_push) u_wr_nx = u_wr + PTR_W'(1);
            if (u_pop)  u_rd_nx = u_rd + PTR_W'(1);
        end

        always_ff @(posedge i_user_clk or negedge i_rst) begin
            if (!i_rst) begin
                h_wr  <= '0;
                h_rd  <= '0;
                h_lvl <= '0;
                u_wr  <= '0;
                u_rd  <= '0;
                u_lvl <= '0;
            end else begin
                h_wr  <= h_wr_nx;
                h_rd  <= h_rd_nx;
                h_lvl <= h_lvl_nx;
                u_wr  <= u_wr_nx;
                u_rd  <= u_rd_nx;
                u_lvl <= u_lvl_nx;
            end
        end

        // Storage carries no reset; outputs are zeroed while the FIFO is empty
        always_ff @(posedge i_user_clk) begin
            if (h_push) h_mem[h_wr] <= i_pcie_str_data[k*DATA_W +: DATA_W];
            if (u_push) u_mem[u_wr] <= u_in_data;
        end

        assign o_pcie_str_ack[k]                    = h_in_ack;
        assign o_usr_str_ack[k]                     = u_in_ack & ~r_lb[k];
        assign o_usr_str_data_valid[k]              = usr_valid;
        assign o_usr_str_data[k*DATA_W +: DATA_W]   = usr_valid ? h_head : '0;
        assign o_pcie_str_data_valid[k]             = ~u_empty;
        assign o_pcie_str_data[k*DATA_W +: DATA_W]  = u_empty ? '0 : u_head;
        assign o_h2u_level[k*LVL_W +: LVL_W]        = h_lvl;
        assign o_u2h_level[k*LVL_W +: LVL_W]        = u_lvl;
    end

endmodule
